// File: rtl/nios_timer_pkg.sv
// Shared definitions for the interval-timer sequencer: register map, control bits, FSM states.
package nios_timer_pkg;

   // Timer slave register addresses
   localparam logic [3:0] TMR_STATUS  = 4'd0;
   localparam logic [3:0] TMR_CONTROL = 4'd1;
   localparam logic [3:0] TMR_PERIOD0 = 4'd2;
   localparam logic [3:0] TMR_PERIOD1 = 4'd3;
   localparam logic [3:0] TMR_PERIOD2 = 4'd4;
   localparam logic [3:0] TMR_PERIOD3 = 4'd5;
   localparam logic [3:0] TMR_SNAP0   = 4'd6;
   localparam logic [3:0] TMR_SNAP1   = 4'd7;
   localparam logic [3:0] TMR_SNAP2   = 4'd8;
   localparam logic [3:0] TMR_SNAP3   = 4'd9;

   // Control register bit indices
   localparam int unsigned ITO   = 0;
   localparam int unsigned CONT  = 1;
   localparam int unsigned START = 2;
   localparam int unsigned STOP  = 3;

   localparam logic [15:0] CTRL_GO_WORD   = 16'((1 << ITO) | (1 << CONT) | (1 << START));
   localparam logic [15:0] CTRL_STOP_WORD = 16'(1 << STOP);

   typedef enum logic [3:0] {
      StIdle,
      StP0,
      StP1,
      StP2,
      StP3,
      StCtrlGo,
      StRun,
      StClr,
      StClrGap,
      StSnapW,
      StSnapR0,
      StSnapR1,
      StSnapCap,
      StCtrlStop
   } tmr_state_e;

   // The timer counts L..0 inclusive, so a period of P clocks needs L = P-1 (minimum period 2).
   function automatic logic [63:0] calc_load(input logic [63:0] period);
      if (period < 64'd2) begin
         return 64'd1;
      end
      return period - 64'd1;
   endfunction

endpackage

// File: rtl/nios_timer_sequencer.sv
// Avalon-MM master that programs, services, stops and snapshots the 64-bit interval timer.
module nios_timer_sequencer
   import nios_timer_pkg::*;
#(
   parameter int unsigned PERIOD_W   = 32,
   parameter int unsigned TICK_W     = 16,
   parameter logic [31:0] DEF_PERIOD = 32'd50000,
   parameter bit          AUTO_START = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_start,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic                cfg_stop,
   input  logic                snap_req,
   output logic [3:0]          tmr_address,
   output logic                tmr_chipselect,
   output logic                tmr_write_n,
   output logic [15:0]         tmr_writedata,
   input  logic [15:0]         tmr_readdata,
   input  logic                tmr_irq,
   output logic                busy,
   output logic                running,
   output logic                tick,
   output logic [TICK_W-1:0]   tick_count,
   output logic                snap_valid,
   output logic [31:0]         snap_value
);

   localparam logic [63:0] DefPeriodExt = 64'(DEF_PERIOD);

   tmr_state_e          state_q, state_d;
   logic                pend_start_q, pend_start_d;
   logic                pend_stop_q, pend_stop_d;
   logic                pend_snap_q, pend_snap_d;
   logic [PERIOD_W-1:0] pend_period_q, pend_period_d;
   logic [63:0]         load_q, load_d;
   logic [63:0]         period_ext;
   logic                running_q, running_d;
   logic [TICK_W-1:0]   tick_count_q, tick_count_d;
   logic [15:0]         snap_lo_q, snap_lo_d;
   logic [31:0]         snap_value_q, snap_value_d;
   logic                snap_valid_q, snap_valid_d;
   logic                snap_ret_q, snap_ret_d;  // 1: snapshot started from RUN

   // Next-state: request latching, sequence selection and capture
   always_comb begin
      state_d       = state_q;
      // A simultaneous stop is discarded in favour of the start
      pend_start_d  = pend_start_q | cfg_start;
      pend_stop_d   = pend_stop_q | (cfg_stop & ~cfg_start);
      pend_snap_d   = pend_snap_q | snap_req;
      pend_period_d = cfg_start ? cfg_period : pend_period_q;
      period_ext    = '0;
      period_ext[PERIOD_W-1:0] = pend_period_d;
      load_d        = load_q;
      running_d     = running_q;
      tick_count_d  = tick_count_q;
      snap_lo_d     = snap_lo_q;
      snap_value_d  = snap_value_q;
      snap_valid_d  = 1'b0;
      snap_ret_d    = snap_ret_q;

      unique case (state_q)
         StIdle: begin
            pend_stop_d = 1'b0;  // nothing to stop
            if (pend_start_d) begin
               state_d      = StP0;
               pend_start_d = 1'b0;
               load_d       = calc_load(period_ext);
            end else if (pend_snap_d) begin
               state_d     = StSnapW;
               pend_snap_d = 1'b0;
               snap_ret_d  = 1'b0;
            end
         end
         StP0:     state_d = StP1;
         StP1:     state_d = StP2;
         StP2:     state_d = StP3;
         StP3:     state_d = StCtrlGo;
         StCtrlGo: begin
            state_d      = StRun;
            running_d    = 1'b1;
            tick_count_d = '0;
         end
         StRun: begin
            if (tmr_irq) begin
               state_d      = StClr;
               tick_count_d = tick_count_q + 1'b1;
            end else if (pend_start_d) begin
               // Reprogram in place; the period writes reload the counter
               state_d      = StP0;
               pend_start_d = 1'b0;
               load_d       = calc_load(period_ext);
            end else if (pend_stop_d) begin
               state_d     = StCtrlStop;
               pend_stop_d = 1'b0;
            end else if (pend_snap_d) begin
               state_d     = StSnapW;
               pend_snap_d = 1'b0;
               snap_ret_d  = 1'b1;
            end
         end
         StClr:    state_d = StClrGap;
         // irq is still high here until the status write lands; skip one cycle
         StClrGap: state_d = StRun;
         StSnapW:  state_d = StSnapR0;
         StSnapR0: state_d = StSnapR1;
         StSnapR1: begin
            state_d   = StSnapCap;
            snap_lo_d = tmr_readdata;
         end
         StSnapCap: begin
            state_d      = snap_ret_q ? StRun : StIdle;
            snap_value_d = {tmr_readdata, snap_lo_q};
            snap_valid_d = 1'b1;
         end
         StCtrlStop: begin
            state_d   = StIdle;
            running_d = 1'b0;
         end
         default:  state_d = StIdle;
      endcase
   end

   // Bus access decode from the current state
   always_comb begin
      tmr_chipselect = 1'b0;
      tmr_write_n    = 1'b1;
      tmr_address    = TMR_STATUS;
      tmr_writedata  = '0;
      unique case (state_q)
         StP0: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = TMR_PERIOD0;
            tmr_writedata  = load_q[15:0];
         end
         StP1: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = TMR_PERIOD1;
            tmr_writedata  = load_q[31:16];
         end
         StP2: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = TMR_PERIOD2;
            tmr_writedata  = load_q[47:32];
         end
         StP3: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = TMR_PERIOD3;
            tmr_writedata  = load_q[63:48];
         end
         StCtrlGo: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = TMR_CONTROL;
            tmr_writedata  = CTRL_GO_WORD;
         end
         StClr: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = TMR_STATUS;
         end
         StSnapW: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = TMR_SNAP0;
         end
         StSnapR0: begin
            tmr_chipselect = 1'b1;
            tmr_address    = TMR_SNAP0;
         end
         StSnapR1: begin
            tmr_chipselect = 1'b1;
            tmr_address    = TMR_SNAP1;
         end
         StCtrlStop: begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = TMR_CONTROL;
            tmr_writedata  = CTRL_STOP_WORD;
         end
         default: ;
      endcase
   end

   // State and register update with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         pend_start_q  <= AUTO_START;
         pend_stop_q   <= 1'b0;
         pend_snap_q   <= 1'b0;
         pend_period_q <= DefPeriodExt[PERIOD_W-1:0];
         load_q        <= '0;
         running_q     <= 1'b0;
         tick_count_q  <= '0;
         snap_lo_q     <= '0;
         snap_value_q  <= '0;
         snap_valid_q  <= 1'b0;
         snap_ret_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pend_start_q  <= pend_start_d;
         pend_stop_q   <= pend_stop_d;
         pend_snap_q   <= pend_snap_d;
         pend_period_q <= pend_period_d;
         load_q        <= load_d;
         running_q     <= running_d;
         tick_count_q  <= tick_count_d;
         snap_lo_q     <= snap_lo_d;
         snap_value_q  <= snap_value_d;
         snap_valid_q  <= snap_valid_d;
         snap_ret_q    <= snap_ret_d;
      end
   end

   assign busy       = (state_q != StIdle) && (state_q != StRun);
   assign running    = running_q;
   assign tick       = (state_q == StClr);
   assign tick_count = tick_count_q;
   assign snap_valid = snap_valid_q;
   assign snap_value = snap_value_q;

endmodule

// File: tb/tb_nios_timer_sequencer.sv
// Self-checking bench for nios_timer_sequencer with a small behavioural timer slave.
module tb_nios_timer_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, cfg_start, cfg_stop, snap_req;
   logic [31:0] cfg_period;
   logic [3:0]  tmr_address;
   logic        tmr_chipselect, tmr_write_n, tmr_irq;
   logic [15:0] tmr_writedata, tmr_readdata;
   logic        busy, running, tick, snap_valid;
   logic [15:0] tick_count;
   logic [31:0] snap_value;

   int n_tests = 0;
   int n_fail  = 0;

   nios_timer_sequencer dut (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_period(cfg_period),
      .cfg_stop(cfg_stop), .snap_req(snap_req), .tmr_address(tmr_address),
      .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
      .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
      .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
      .snap_valid(snap_valid), .snap_value(snap_value)
   );

   // Narrow tick counter instance for the wrap check
   logic       tie0 = 1'b0;
   logic [15:0] tie16 = 16'h0;
   logic       start2, irq2;
   logic [31:0] period2 = 32'd8;
   logic [3:0] addr2, addr3;
   logic       cs2, wn2, busy2, run2, tick2, sv2;
   logic       cs3, wn3, busy3, run3, tick3, sv3;
   logic [15:0] wd2, wd3, tc3;
   logic [3:0] tc2;
   logic [31:0] snv2, snv3;

   nios_timer_sequencer #(.TICK_W(4)) dut2 (
      .clk(clk), .reset(reset), .cfg_start(start2), .cfg_period(period2),
      .cfg_stop(tie0), .snap_req(tie0), .tmr_address(addr2), .tmr_chipselect(cs2),
      .tmr_write_n(wn2), .tmr_writedata(wd2), .tmr_readdata(tie16), .tmr_irq(irq2),
      .busy(busy2), .running(run2), .tick(tick2), .tick_count(tc2),
      .snap_valid(sv2), .snap_value(snv2)
   );

   nios_timer_sequencer #(.AUTO_START(1'b1)) dut3 (
      .clk(clk), .reset(reset), .cfg_start(tie0), .cfg_period(period2),
      .cfg_stop(tie0), .snap_req(tie0), .tmr_address(addr3), .tmr_chipselect(cs3),
      .tmr_write_n(wn3), .tmr_writedata(wd3), .tmr_readdata(tie16), .tmr_irq(tie0),
      .busy(busy3), .running(run3), .tick(tick3), .tick_count(tc3),
      .snap_valid(sv3), .snap_value(snv3)
   );

   // Behavioural timer slave
   logic [63:0] m_period, m_count, m_snap;
   logic        m_run, m_irq;
   logic [15:0] m_rdata;
   logic        snap_force;
   logic [63:0] snap_force_val;
   logic        irq_manual, irq_man;

   assign tmr_irq      = irq_manual ? irq_man : m_irq;
   assign tmr_readdata = m_rdata;

   always @(posedge clk) begin
      if (reset) begin
         m_period <= '0; m_count <= '0; m_snap <= '0; m_run <= 1'b0; m_irq <= 1'b0;
         m_rdata  <= '0;
      end else begin
         if (m_run) begin
            if (m_count == 64'd0) begin
               m_count <= m_period;
               m_irq   <= 1'b1;
            end else begin
               m_count <= m_count - 64'd1;
            end
         end
         if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
               4'd0: m_irq <= 1'b0;
               4'd1: begin
                  if (tmr_writedata[2]) m_run <= 1'b1;
                  if (tmr_writedata[3]) m_run <= 1'b0;
               end
               4'd2: begin
                  m_period[15:0] <= tmr_writedata;
                  m_count <= {m_period[63:16], tmr_writedata}; m_run <= 1'b0;
               end
               4'd3: begin
                  m_period[31:16] <= tmr_writedata;
                  m_count <= {m_period[63:32], tmr_writedata, m_period[15:0]}; m_run <= 1'b0;
               end
               4'd4: begin
                  m_period[47:32] <= tmr_writedata;
                  m_count <= {m_period[63:48], tmr_writedata, m_period[31:0]}; m_run <= 1'b0;
               end
               4'd5: begin
                  m_period[63:48] <= tmr_writedata;
                  m_count <= {tmr_writedata, m_period[47:0]}; m_run <= 1'b0;
               end
               4'd6: m_snap <= snap_force ? snap_force_val : m_count;
               default: ;
            endcase
         end
         if (tmr_chipselect && tmr_write_n) begin
            case (tmr_address)
               4'd6:    m_rdata <= m_snap[15:0];
               4'd7:    m_rdata <= m_snap[31:16];
               default: m_rdata <= 16'h0;
            endcase
         end
      end
   end

   // Bus access log: {address, write_n, write data (0 for reads)}
   typedef struct packed {
      logic [3:0]  a;
      logic        wn;
      logic [15:0] d;
   } acc_t;
   acc_t log_q[$];
   acc_t exp_q[$];

   always @(negedge clk) begin
      if (tmr_chipselect) log_q.push_back({tmr_address, tmr_write_n,
                                           tmr_write_n ? 16'h0 : tmr_writedata});
   end

   function automatic acc_t wr(input logic [3:0] a, input logic [15:0] d);
      return {a, 1'b0, d};
   endfunction

   function automatic acc_t rd(input logic [3:0] a);
      return {a, 1'b1, 16'h0};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_log(input string name, input int base);
      chk({name, " count"}, 64'(log_q.size() - base), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < log_q.size())
            chk($sformatf("%s acc%0d", name, i), 64'(log_q[base + i]), 64'(exp_q[i]));
         else
            chk($sformatf("%s acc%0d missing", name, i), 64'hDEAD_0000_0000, 64'(exp_q[i]));
      end
      exp_q.delete();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " cs"}, 64'(tmr_chipselect), 64'd0);
      chk({tag, " write_n"}, 64'(tmr_write_n), 64'd1);
      chk({tag, " addr"}, 64'(tmr_address), 64'd0);
      chk({tag, " wdata"}, 64'(tmr_writedata), 64'd0);
      chk({tag, " busy"}, 64'(busy), 64'd0);
      chk({tag, " running"}, 64'(running), 64'd0);
      chk({tag, " tick"}, 64'(tick), 64'd0);
      chk({tag, " tick_count"}, 64'(tick_count), 64'd0);
      chk({tag, " snap_valid"}, 64'(snap_valid), 64'd0);
      chk({tag, " snap_value"}, 64'(snap_value), 64'd0);
   endtask

   typedef struct {
      logic        start;
      logic [31:0] period;
      logic        irq;
      logic        cs;
      logic        wn;
      logic [3:0]  addr;
      logic [15:0] wd;
      logic        busy;
      logic        run;
      logic        tick;
      logic [15:0] tcnt;
   } vec_t;
   vec_t vecs[9];

   int          base;
   int          tcyc[$];
   logic [15:0] tval[$];
   int          nticks;

   initial begin
      // Start from IDLE, period 50000 (L=0xC34F), then one serviced timeout
      vecs[0] = '{1'b1, 32'd50000, 1'b0, 1'b1, 1'b0, 4'd2, 16'hC34F, 1'b1, 1'b0, 1'b0, 16'd0};
      vecs[1] = '{1'b0, 32'd0,     1'b0, 1'b1, 1'b0, 4'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0};
      vecs[2] = '{1'b0, 32'd0,     1'b0, 1'b1, 1'b0, 4'd4, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0};
      vecs[3] = '{1'b0, 32'd0,     1'b0, 1'b1, 1'b0, 4'd5, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0};
      vecs[4] = '{1'b0, 32'd0,     1'b0, 1'b1, 1'b0, 4'd1, 16'h0007, 1'b1, 1'b0, 1'b0, 16'd0};
      vecs[5] = '{1'b0, 32'd0,     1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd0};
      vecs[6] = '{1'b0, 32'd0,     1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'd1};
      vecs[7] = '{1'b0, 32'd0,     1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd1};
      vecs[8] = '{1'b0, 32'd0,     1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd1};

      reset = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; snap_req = 1'b0; cfg_period = '0;
      irq_manual = 1'b1; irq_man = 1'b0; snap_force = 1'b0; snap_force_val = '0;
      start2 = 1'b0; irq2 = 1'b0;
      repeat (3) step();
      chk_reset_vals("reset");
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         cfg_start = vecs[i].start; cfg_period = vecs[i].period; irq_man = vecs[i].irq;
         step();
         chk($sformatf("vec%0d cs", i), 64'(tmr_chipselect), 64'(vecs[i].cs));
         chk($sformatf("vec%0d write_n", i), 64'(tmr_write_n), 64'(vecs[i].wn));
         chk($sformatf("vec%0d addr", i), 64'(tmr_address), 64'(vecs[i].addr));
         chk($sformatf("vec%0d wdata", i), 64'(tmr_writedata), 64'(vecs[i].wd));
         chk($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].busy));
         chk($sformatf("vec%0d running", i), 64'(running), 64'(vecs[i].run));
         chk($sformatf("vec%0d tick", i), 64'(tick), 64'(vecs[i].tick));
         chk($sformatf("vec%0d tick_count", i), 64'(tick_count), 64'(vecs[i].tcnt));
      end
      irq_man = 1'b0;

      // Period 4 with the timer model driving irq: one tick every 4 cycles
      cfg_start = 1'b1; cfg_period = 32'd4;
      step();
      cfg_start = 1'b0; irq_manual = 1'b0;
      repeat (5) step();
      chk("p4 running", 64'(running), 64'd1);
      chk("p4 tick_count cleared", 64'(tick_count), 64'd0);
      for (int c = 0; c < 40 && tcyc.size() < 3; c++) begin
         step();
         if (tick) begin
            tcyc.push_back(c);
            tval.push_back(tick_count);
         end
      end
      chk("p4 ticks seen", 64'(tcyc.size()), 64'd3);
      for (int i = 0; i < tcyc.size(); i++)
         chk($sformatf("p4 tick_count %0d", i), 64'(tval[i]), 64'(i + 1));
      for (int i = 1; i < tcyc.size(); i++)
         chk($sformatf("p4 interval %0d", i), 64'(tcyc[i] - tcyc[i-1]), 64'd4);
      irq_manual = 1'b1; irq_man = 1'b0;
      repeat (3) step();

      // Reprogram from RUN with period 100000 (L=0x1869F)
      base = log_q.size();
      cfg_start = 1'b1; cfg_period = 32'd100000;
      step();
      cfg_start = 1'b0;
      repeat (5) step();
      chk("p100k running", 64'(running), 64'd1);
      exp_q = '{wr(4'd2, 16'h869F), wr(4'd3, 16'h0001), wr(4'd4, 16'h0), wr(4'd5, 16'h0),
                wr(4'd1, 16'h0007)};
      chk_log("p100k", base);

      // Snapshot from RUN
      snap_force = 1'b1; snap_force_val = 64'h0000_ABCD_0001_2345;
      base = log_q.size();
      snap_req = 1'b1;
      step();
      snap_req = 1'b0;
      chk("snap busy", 64'(busy), 64'd1);
      repeat (3) step();
      chk("snap valid early", 64'(snap_valid), 64'd0);
      step();
      chk("snap valid", 64'(snap_valid), 64'd1);
      chk("snap value", 64'(snap_value), 64'h0001_2345);
      chk("snap back in run", 64'(busy), 64'd0);
      chk("snap running", 64'(running), 64'd1);
      step();
      chk("snap valid one cycle", 64'(snap_valid), 64'd0);
      exp_q = '{wr(4'd6, 16'h0), rd(4'd6), rd(4'd7)};
      chk_log("snap", base);

      // Stop and snap together while irq is high
      snap_force_val = 64'h0000_0000_BEEF_0042;
      base = log_q.size();
      irq_man = 1'b1; cfg_stop = 1'b1; snap_req = 1'b1;
      step();
      irq_man = 1'b0; cfg_stop = 1'b0; snap_req = 1'b0;
      chk("stopsnap clr tick", 64'(tick), 64'd1);
      repeat (9) step();
      chk("stopsnap valid", 64'(snap_valid), 64'd1);
      chk("stopsnap value", 64'(snap_value), 64'hBEEF_0042);
      chk("stopsnap running", 64'(running), 64'd0);
      chk("stopsnap busy", 64'(busy), 64'd0);
      exp_q = '{wr(4'd0, 16'h0), wr(4'd1, 16'h0008), wr(4'd6, 16'h0), rd(4'd6), rd(4'd7)};
      chk_log("stopsnap", base);

      // Period 1 and 0 both load L=1; a start during P2 queues a second program
      base = log_q.size();
      cfg_start = 1'b1; cfg_period = 32'd1;
      step();
      cfg_start = 1'b0;
      repeat (6) step();
      cfg_start = 1'b1; cfg_period = 32'd0;
      step();
      cfg_start = 1'b0;
      repeat (6) step();
      cfg_start = 1'b1; cfg_period = 32'd10;
      step();
      cfg_start = 1'b0;
      repeat (2) step();
      chk("p2 state addr", 64'(tmr_address), 64'd4);
      cfg_start = 1'b1; cfg_period = 32'h0002_0001;
      step();
      cfg_start = 1'b0;
      repeat (10) step();
      chk("requeue running", 64'(running), 64'd1);
      chk("requeue idle bus", 64'(busy), 64'd0);
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(wr(4'd2, 16'h0001)); exp_q.push_back(wr(4'd3, 16'h0));
         exp_q.push_back(wr(4'd4, 16'h0));    exp_q.push_back(wr(4'd5, 16'h0));
         exp_q.push_back(wr(4'd1, 16'h0007));
      end
      exp_q.push_back(wr(4'd2, 16'h0009)); exp_q.push_back(wr(4'd3, 16'h0));
      exp_q.push_back(wr(4'd4, 16'h0));    exp_q.push_back(wr(4'd5, 16'h0));
      exp_q.push_back(wr(4'd1, 16'h0007));
      exp_q.push_back(wr(4'd2, 16'h0000)); exp_q.push_back(wr(4'd3, 16'h0002));
      exp_q.push_back(wr(4'd4, 16'h0));    exp_q.push_back(wr(4'd5, 16'h0));
      exp_q.push_back(wr(4'd1, 16'h0007));
      chk_log("minper", base);

      // Reset in P1 aborts the sequence
      cfg_start = 1'b1; cfg_period = 32'd50000;
      step();
      cfg_start = 1'b0;
      step();
      chk("p1 addr", 64'(tmr_address), 64'd3);
      reset = 1'b1;
      step();
      chk_reset_vals("midreset");
      reset = 1'b0;
      step();
      chk("after reset cs 0", 64'(tmr_chipselect), 64'd0);
      chk("autostart cs", 64'(cs3), 64'd1);
      chk("autostart addr", 64'(addr3), 64'd2);
      chk("autostart wdata", 64'(wd3), 64'hC34F);
      step();
      chk("after reset cs 1", 64'(tmr_chipselect), 64'd0);
      step();
      chk("after reset cs 2", 64'(tmr_chipselect), 64'd0);
      repeat (3) step();
      chk("autostart running", 64'(run3), 64'd1);
      chk("idle after reset", 64'(running), 64'd0);

      // TICK_W=4: 17 serviced timeouts wrap the count to 1
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      repeat (5) step();
      chk("w4 running", 64'(run2), 64'd1);
      nticks = 0;
      for (int k = 0; k < 17; k++) begin
         irq2 = 1'b1;
         step();
         if (tick2) nticks++;
         irq2 = 1'b0;
         step();
         if (tick2) nticks++;
         step();
         if (tick2) nticks++;
      end
      chk("w4 tick pulses", 64'(nticks), 64'd17);
      chk("w4 tick_count wrap", 64'(tc2), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
